// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared types, vectors and helpers for the 6502 interrupt controller
package int_pkg;

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;
  typedef enum logic [1:0] {RST, NMI, IRQ} kind_t;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  function automatic logic [15:0] vec_of(input kind_t k);
    case (k)
      RST:     vec_of = VEC_RST;
      NMI:     vec_of = VEC_NMI;
      default: vec_of = VEC_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/int_sync.sv
// rtl/int_sync.sv - N-bit synchroniser bank, resets to all-ones (pins inactive)
module int_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk | rst;
      assign q = d;
    end else begin : g_sync
      logic [W-1:0] stage [STAGES];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) stage[i] <= '1;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - RST/NMI/IRQ arbitration at instruction boundaries with request/ack handshake
module int_ctrl
  import int_pkg::*;
#(
  parameter int  NUM_IRQ     = 4,
  parameter int  SYNC_STAGES = 2,
  localparam int SRC_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rst_req_n,
  input  logic               nmi_n,
  input  logic [NUM_IRQ-1:0] irq_n,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               i_flag,
  input  logic               sync,
  input  logic               ack,
  output logic               take_rst,
  output logic               take_nmi,
  output logic               take_irq,
  output logic [15:0]        vector,
  output logic [SRC_W-1:0]   irq_src,
  output logic [NUM_IRQ-1:0] irq_pend
);

  logic [NUM_IRQ+1:0] pins_s;
  logic               rst_s;
  logic               nmi_s;
  logic               nmi_s_d;
  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] elig;
  logic               rst_latch;
  logic               nmi_latch;
  logic               nmi_fall;
  logic               ack_ok;
  logic               present;
  state_t             state, state_nx;
  kind_t              kind, kind_nx;
  logic [SRC_W-1:0]   src_nx;
  logic [SRC_W-1:0]   src_pick;

  int_sync #(
    .W      (NUM_IRQ + 2),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({rst_req_n, nmi_n, irq_n}),
    .q   (pins_s)
  );

  assign rst_s    = pins_s[NUM_IRQ+1];
  assign nmi_s    = pins_s[NUM_IRQ];
  assign irq_s    = pins_s[NUM_IRQ-1:0];
  assign irq_pend = ~irq_s & irq_en;
  assign elig     = irq_pend & {NUM_IRQ{~i_flag}};
  assign nmi_fall = nmi_s_d & ~nmi_s;
  // A held reset pin makes the CPU's ack meaningless: it must not retire the reset request.
  assign ack_ok   = ack & rst_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_latch <= 1'b1;
      nmi_latch <= 1'b0;
      nmi_s_d   <= 1'b1;
    end else begin
      nmi_s_d <= nmi_s;
      if (!rst_s)
        rst_latch <= 1'b1;
      else if (ack_ok && state == REQ && kind == RST)
        rst_latch <= 1'b0;
      // A fresh edge beats a simultaneous clear so that NMI is never lost.
      if (nmi_fall)
        nmi_latch <= 1'b1;
      else if (ack_ok && state == REQ && kind == NMI)
        nmi_latch <= 1'b0;
    end
  end

  always_comb begin
    src_pick = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) src_pick = i[SRC_W-1:0];
    end
  end

  always_comb begin
    state_nx = state;
    kind_nx  = kind;
    src_nx   = irq_src;
    if (!rst_s || (rst_latch && !(state == REQ && kind == RST))) begin
      state_nx = REQ;
      kind_nx  = RST;
      src_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sync && nmi_latch) begin
            state_nx = REQ;
            kind_nx  = NMI;
            src_nx   = '0;
          end else if (sync && |elig) begin
            state_nx = REQ;
            kind_nx  = IRQ;
            src_nx   = src_pick;
          end
        end
        REQ:     if (ack_ok) state_nx = SVC;
        // Leaving SVC consumes the sync without arbitrating, so one handler opcode runs.
        SVC:     if (sync) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign present = (state_nx == REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= REQ;
      kind     <= RST;
      take_rst <= 1'b1;
      take_nmi <= 1'b0;
      take_irq <= 1'b0;
      vector   <= VEC_RST;
      irq_src  <= '0;
    end else begin
      state    <= state_nx;
      kind     <= kind_nx;
      take_rst <= present && kind_nx == RST;
      take_nmi <= present && kind_nx == NMI;
      take_irq <= present && kind_nx == IRQ;
      vector   <= present ? vec_of(kind_nx) : 16'h0000;
      irq_src  <= present ? src_nx : '0;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed vector bench for int_ctrl
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_req_n, nmi_n, i_flag, sync, ack;
  logic [3:0] irq_n, irq_en;
  logic       take_rst, take_nmi, take_irq;
  logic [15:0] vector;
  logic [1:0] irq_src;
  logic [3:0] irq_pend;

  logic       rst_req_n0, nmi_n0, i_flag0, sync0, ack0;
  logic [3:0] irq_n0, irq_en0;
  logic       take_rst0, take_nmi0, take_irq0;
  logic [15:0] vector0;
  logic [1:0] irq_src0;
  logic [3:0] irq_pend0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  int_ctrl #(.NUM_IRQ(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rst_req_n(rst_req_n), .nmi_n(nmi_n), .irq_n(irq_n),
    .irq_en(irq_en), .i_flag(i_flag), .sync(sync), .ack(ack),
    .take_rst(take_rst), .take_nmi(take_nmi), .take_irq(take_irq),
    .vector(vector), .irq_src(irq_src), .irq_pend(irq_pend)
  );

  int_ctrl #(.NUM_IRQ(4), .SYNC_STAGES(0)) dut0 (
    .clk(clk), .rst(rst), .rst_req_n(rst_req_n0), .nmi_n(nmi_n0), .irq_n(irq_n0),
    .irq_en(irq_en0), .i_flag(i_flag0), .sync(sync0), .ack(ack0),
    .take_rst(take_rst0), .take_nmi(take_nmi0), .take_irq(take_irq0),
    .vector(vector0), .irq_src(irq_src0), .irq_pend(irq_pend0)
  );

  typedef struct {
    logic        rq;
    logic        nmi;
    logic [3:0]  irq;
    logic [3:0]  en;
    logic        ifl;
    logic        sy;
    logic        ak;
    logic [2:0]  take;
    logic [15:0] vec;
    logic [1:0]  src;
    logic [3:0]  pend;
  } vec_t;

  localparam logic [2:0] TR = 3'b100;
  localparam logic [2:0] TN = 3'b010;
  localparam logic [2:0] TI = 3'b001;
  localparam logic [2:0] T0 = 3'b000;

  vec_t tbl [44];

  function automatic vec_t mk(input logic rq, input logic nmi, input logic [3:0] irq,
                              input logic [3:0] en, input logic ifl, input logic sy,
                              input logic ak, input logic [2:0] take, input logic [15:0] vec,
                              input logic [1:0] src, input logic [3:0] pend);
    vec_t v;
    v.rq = rq; v.nmi = nmi; v.irq = irq; v.en = en; v.ifl = ifl; v.sy = sy; v.ak = ak;
    v.take = take; v.vec = vec; v.src = src; v.pend = pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              rq nmi irq    en    ifl sy ak take vec      src pend
    tbl[0]  = mk(1, 1, 4'hF, 4'hF, 0, 0, 0, TR, 16'hFFFC, 0, 4'h0);
    tbl[1]  = mk(1, 1, 4'hF, 4'hF, 0, 1, 0, TR, 16'hFFFC, 0, 4'h0);
    tbl[2]  = mk(1, 1, 4'hF, 4'hF, 0, 0, 1, T0, 16'h0000, 0, 4'h0);
    tbl[3]  = mk(1, 1, 4'hF, 4'hF, 0, 0, 0, T0, 16'h0000, 0, 4'h0);
    tbl[4]  = mk(1, 1, 4'hF, 4'hF, 0, 1, 0, T0, 16'h0000, 0, 4'h0);
    tbl[5]  = mk(1, 1, 4'hF, 4'hF, 0, 1, 0, T0, 16'h0000, 0, 4'h0);
    tbl[6]  = mk(1, 1, 4'hF, 4'hF, 0, 0, 1, T0, 16'h0000, 0, 4'h0);
    tbl[7]  = mk(1, 1, 4'h5, 4'hF, 0, 0, 0, T0, 16'h0000, 0, 4'h0);
    tbl[8]  = mk(1, 1, 4'h5, 4'hF, 0, 0, 0, T0, 16'h0000, 0, 4'hA);
    tbl[9]  = mk(1, 1, 4'h5, 4'hF, 0, 1, 0, TI, 16'hFFFE, 1, 4'hA);
    tbl[10] = mk(1, 1, 4'h7, 4'hF, 0, 0, 0, TI, 16'hFFFE, 1, 4'hA);
    tbl[11] = mk(1, 1, 4'h7, 4'hF, 0, 1, 0, TI, 16'hFFFE, 1, 4'h8);
    tbl[12] = mk(1, 1, 4'hF, 4'hF, 0, 0, 1, T0, 16'h0000, 0, 4'h8);
    tbl[13] = mk(1, 1, 4'hF, 4'hF, 0, 1, 0, T0, 16'h0000, 0, 4'h0);
    tbl[14] = mk(1, 1, 4'hE, 4'hF, 1, 0, 0, T0, 16'h0000, 0, 4'h0);
    tbl[15] = mk(1, 1, 4'hE, 4'hF, 1, 0, 0, T0, 16'h0000, 0, 4'h1);
    tbl[16] = mk(1, 1, 4'hE, 4'hF, 1, 1, 0, T0, 16'h0000, 0, 4'h1);
    tbl[17] = mk(1, 1, 4'hE, 4'hE, 0, 1, 0, T0, 16'h0000, 0, 4'h0);
    tbl[18] = mk(1, 1, 4'hF, 4'hF, 0, 0, 0, T0, 16'h0000, 0, 4'h1);
    tbl[19] = mk(1, 1, 4'hF, 4'hF, 0, 0, 0, T0, 16'h0000, 0, 4'h0);
    tbl[20] = mk(1, 0, 4'hB, 4'hF, 0, 0, 0, T0, 16'h0000, 0, 4'h0);
    tbl[21] = mk(1, 1, 4'hB, 4'hF, 0, 0, 0, T0, 16'h0000, 0, 4'h4);
    tbl[22] = mk(1, 1, 4'hB, 4'hF, 0, 0, 0, T0, 16'h0000, 0, 4'h4);
    tbl[23] = mk(1, 1, 4'hB, 4'hF, 0, 1, 0, TN, 16'hFFFA, 0, 4'h4);
    tbl[24] = mk(1, 0, 4'hF, 4'hF, 0, 0, 0, TN, 16'hFFFA, 0, 4'h4);
    tbl[25] = mk(1, 1, 4'hF, 4'hF, 0, 0, 0, TN, 16'hFFFA, 0, 4'h0);
    tbl[26] = mk(1, 1, 4'hF, 4'hF, 0, 0, 1, T0, 16'h0000, 0, 4'h0);
    tbl[27] = mk(1, 1, 4'hF, 4'hF, 0, 1, 0, T0, 16'h0000, 0, 4'h0);
    tbl[28] = mk(1, 1, 4'hF, 4'hF, 0, 1, 0, TN, 16'hFFFA, 0, 4'h0);
    tbl[29] = mk(1, 1, 4'hF, 4'hF, 0, 0, 1, T0, 16'h0000, 0, 4'h0);
    tbl[30] = mk(1, 1, 4'hF, 4'hF, 0, 1, 0, T0, 16'h0000, 0, 4'h0);
    tbl[31] = mk(1, 1, 4'hF, 4'hF, 0, 1, 0, T0, 16'h0000, 0, 4'h0);
    tbl[32] = mk(1, 1, 4'h7, 4'hF, 0, 0, 0, T0, 16'h0000, 0, 4'h0);
    tbl[33] = mk(1, 1, 4'h7, 4'hF, 0, 0, 0, T0, 16'h0000, 0, 4'h8);
    tbl[34] = mk(1, 1, 4'h7, 4'hF, 0, 1, 0, TI, 16'hFFFE, 3, 4'h8);
    tbl[35] = mk(0, 1, 4'h7, 4'hF, 0, 0, 0, TI, 16'hFFFE, 3, 4'h8);
    tbl[36] = mk(0, 1, 4'h7, 4'hF, 0, 0, 0, TI, 16'hFFFE, 3, 4'h8);
    tbl[37] = mk(0, 1, 4'h7, 4'hF, 0, 0, 1, TR, 16'hFFFC, 0, 4'h8);
    tbl[38] = mk(1, 1, 4'hF, 4'hF, 0, 0, 1, TR, 16'hFFFC, 0, 4'h8);
    tbl[39] = mk(1, 1, 4'hF, 4'hF, 0, 0, 1, TR, 16'hFFFC, 0, 4'h0);
    tbl[40] = mk(1, 1, 4'hF, 4'hF, 0, 0, 0, TR, 16'hFFFC, 0, 4'h0);
    tbl[41] = mk(1, 1, 4'hF, 4'hF, 0, 1, 1, T0, 16'h0000, 0, 4'h0);
    tbl[42] = mk(1, 1, 4'hF, 4'hF, 0, 1, 0, T0, 16'h0000, 0, 4'h0);
    tbl[43] = mk(1, 1, 4'hF, 4'hF, 0, 1, 0, T0, 16'h0000, 0, 4'h0);

    rst = 1'b1;
    rst_req_n = 1'b1; nmi_n = 1'b1; irq_n = 4'hF; irq_en = 4'hF;
    i_flag = 1'b0; sync = 1'b0; ack = 1'b0;
    rst_req_n0 = 1'b1; nmi_n0 = 1'b1; irq_n0 = 4'hF; irq_en0 = 4'hF;
    i_flag0 = 1'b0; sync0 = 1'b0; ack0 = 1'b0;
    step();
    step();
    check("reset take", {29'd0, take_rst, take_nmi, take_irq}, {29'd0, TR});
    check("reset vector", {16'd0, vector}, 32'h0000FFFC);
    check("reset irq_src", {30'd0, irq_src}, 32'd0);
    check("reset0 take", {29'd0, take_rst0, take_nmi0, take_irq0}, {29'd0, TR});
    rst = 1'b0;

    for (int k = 0; k < 44; k++) begin
      rst_req_n = tbl[k].rq; nmi_n = tbl[k].nmi; irq_n = tbl[k].irq; irq_en = tbl[k].en;
      i_flag = tbl[k].ifl; sync = tbl[k].sy; ack = tbl[k].ak;
      step();
      check($sformatf("v%0d take", k), {29'd0, take_rst, take_nmi, take_irq}, {29'd0, tbl[k].take});
      check($sformatf("v%0d vector", k), {16'd0, vector}, {16'd0, tbl[k].vec});
      check($sformatf("v%0d irq_src", k), {30'd0, irq_src}, {30'd0, tbl[k].src});
      check($sformatf("v%0d irq_pend", k), {28'd0, irq_pend}, {28'd0, tbl[k].pend});
    end
    sync = 1'b0; ack = 1'b0;

    // Zero-stage instance: retire reset, return to IDLE, then a pin fall coinciding with sync.
    ack0 = 1'b1;
    step();
    check("s0 ack take", {29'd0, take_rst0, take_nmi0, take_irq0}, 32'd0);
    ack0 = 1'b0; sync0 = 1'b1;
    step();
    check("s0 idle take", {29'd0, take_rst0, take_nmi0, take_irq0}, 32'd0);
    irq_n0 = 4'hE;
    #1;
    check("s0 pend comb", {28'd0, irq_pend0}, 32'h1);
    check("s0 pre take", {29'd0, take_rst0, take_nmi0, take_irq0}, 32'd0);
    step();
    sync0 = 1'b0;
    check("s0 take", {29'd0, take_rst0, take_nmi0, take_irq0}, {29'd0, TI});
    check("s0 vector", {16'd0, vector0}, 32'h0000FFFE);
    check("s0 irq_src", {30'd0, irq_src0}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
